// File: rtl/pipeline_ctrl_if.sv
// Hazard/freeze control bundle between the pipeline datapath and pipeline_ctrl.
// master drives the decode/execute/memory status; slave returns enables, flushes and counters.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_AW;
  logic        ex_er;
  logic        ex_pcsrc;
  logic        mem_er;
  logic        mem_ew;
  logic        pc_we;
  logic        b1_we;
  logic        b2_we;
  logic        b3_we;
  logic        b4_we;
  logic        b1_flush;
  logic        b2_flush;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_AW, ex_er, ex_pcsrc, mem_er, mem_ew,
    input  pc_we, b1_we, b2_we, b3_we, b4_we, b1_flush, b2_flush,
    input  ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_AW, ex_er, ex_pcsrc, mem_er, mem_ew,
    output pc_we, b1_we, b2_we, b3_we, b4_we, b1_flush, b2_flush,
    output ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-latency freeze, branch flush and load-use stall,
// with saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1} state_t;

  localparam bit         HAS_LAT = (MEM_LAT != 0);
  localparam logic [3:0] LAT_M1  = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        rel;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic lu_hazard, mem_req, freeze, branch, lu_stall;
  logic pc_we, b1_we, b2_we, b3_we, b4_we, b1_flush, b2_flush;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign lu_hazard = bus.ex_er & (bus.ex_AW != 5'd0) &
                     ((bus.ex_AW == bus.id_rs) | (bus.id_uses_rt & (bus.ex_AW == bus.id_rt)));
  assign mem_req   = (bus.mem_er | bus.mem_ew) & HAS_LAT;

  // The release cycle (MEM_WAIT, cnt == 0) ignores mem_req; rel then masks it for one RUN cycle.
  assign freeze   = ((state == RUN) && !rel && mem_req) || ((state == MEM_WAIT) && (cnt != 4'd0));
  assign branch   = !freeze && bus.ex_pcsrc;
  assign lu_stall = !freeze && !bus.ex_pcsrc && lu_hazard;

  always_comb begin
    pc_we    = 1'b1;
    b1_we    = 1'b1;
    b2_we    = 1'b1;
    b3_we    = 1'b1;
    b4_we    = 1'b1;
    b1_flush = 1'b0;
    b2_flush = 1'b0;
    if (rst) begin
      {pc_we, b1_we, b2_we, b3_we, b4_we} = 5'b00000;
      b1_flush = 1'b1;
      b2_flush = 1'b1;
    end else if (freeze) begin
      {pc_we, b1_we, b2_we, b3_we, b4_we} = 5'b00000;
    end else begin
      pc_we    = !lu_stall;
      b1_we    = !lu_stall;
      b1_flush = branch;
      b2_flush = branch || lu_stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 4'd0;
      rel       <= 1'b0;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (!rel && mem_req) begin
            state <= MEM_WAIT;
            cnt   <= LAT_M1;
          end
          rel <= 1'b0;
        end
        MEM_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RUN;
            rel   <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
          rel   <= 1'b0;
        end
      endcase
      if (!pc_we) stall_cnt <= sat_inc(stall_cnt);
      if (branch) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.pc_we      = pc_we;
  assign bus.b1_we      = b1_we;
  assign bus.b2_we      = b2_we;
  assign bus.b3_we      = b3_we;
  assign bus.b4_we      = b4_we;
  assign bus.b1_flush   = b1_flush;
  assign bus.b2_flush   = b2_flush;
  assign bus.ctrl_state = state;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_LAT = 2): reset, load-use, branch, freeze and saturation.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst;
  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // {pc_we, b1_we, b2_we, b3_we, b4_we, b1_flush, b2_flush}
  localparam logic [6:0] O_NORMAL = 7'b1111100;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_RESET  = 7'b0000011;
  localparam logic [6:0] O_BRANCH = 7'b1111111;
  localparam logic [6:0] O_LU     = 7'b0011101;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  function automatic logic [6:0] outs();
    return {bus.pc_we, bus.b1_we, bus.b2_we, bus.b3_we, bus.b4_we, bus.b1_flush, bus.b2_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.ex_AW = 5'd0; bus.ex_er = 1'b0; bus.ex_pcsrc = 1'b0;
    bus.mem_er = 1'b0; bus.mem_ew = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_RESET) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs(), O_RESET); end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL) begin n_fail++; $display("FAIL post_reset_outs: got %b expected %b", outs(), O_NORMAL); end
    n_checks++;
    if (bus.ctrl_state !== 2'd0 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d stall=%h flush=%h expected 0 0000 0000",
               bus.ctrl_state, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_load_use();
    tick();
    bus.ex_er = 1'b1; bus.ex_AW = 5'd5; bus.id_rs = 5'd5;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_LU) begin n_fail++; $display("FAIL lu_outs: got %b expected %b", outs(), O_LU); end
    exp_stall = exp_stall + 16'd1;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL) begin n_fail++; $display("FAIL lu_after_outs: got %b expected %b", outs(), O_NORMAL); end
    n_checks++;
    if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL lu_stall_cnt: got %h expected %h", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_no_hazard();
    tick();
    bus.ex_er = 1'b1; bus.ex_AW = 5'd0; bus.id_rs = 5'd0;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL) begin n_fail++; $display("FAIL nohaz_r0_outs: got %b expected %b", outs(), O_NORMAL); end
    tick();
    bus.ex_AW = 5'd7; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b0; bus.id_rs = 5'd3;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL) begin n_fail++; $display("FAIL nohaz_rt_outs: got %b expected %b", outs(), O_NORMAL); end
    tick();
    bus.id_uses_rt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_LU) begin n_fail++; $display("FAIL rt_hazard_outs: got %b expected %b", outs(), O_LU); end
    exp_stall = exp_stall + 16'd1;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL rt_stall_cnt: got %h expected %h", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_branch();
    tick();
    bus.ex_pcsrc = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_BRANCH) begin n_fail++; $display("FAIL branch_outs: got %b expected %b", outs(), O_BRANCH); end
    tick();
    bus.ex_er = 1'b1; bus.ex_AW = 5'd9; bus.id_rs = 5'd9;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_BRANCH) begin n_fail++; $display("FAIL branch_over_lu_outs: got %b expected %b", outs(), O_BRANCH); end
    exp_flush = exp_flush + 16'd2;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.flush_cnt !== exp_flush || bus.stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL branch_cnts: got flush=%h stall=%h expected flush=%h stall=%h",
               bus.flush_cnt, bus.stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_mem_freeze();
    tick();
    bus.mem_ew = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_FREEZE || bus.ctrl_state !== 2'd0) begin
      n_fail++; $display("FAIL freeze1: got %b state %0d expected %b state 0", outs(), bus.ctrl_state, O_FREEZE);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_FREEZE || bus.ctrl_state !== 2'd1) begin
      n_fail++; $display("FAIL freeze2: got %b state %0d expected %b state 1", outs(), bus.ctrl_state, O_FREEZE);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL || bus.ctrl_state !== 2'd1) begin
      n_fail++; $display("FAIL release: got %b state %0d expected %b state 1", outs(), bus.ctrl_state, O_NORMAL);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL || bus.ctrl_state !== 2'd0) begin
      n_fail++; $display("FAIL rel_suppress: got %b state %0d expected %b state 0", outs(), bus.ctrl_state, O_NORMAL);
    end
    exp_stall = exp_stall + 16'd2;
    n_checks++;
    if (bus.stall_cnt !== exp_stall) begin n_fail++; $display("FAIL freeze_stall_cnt: got %h expected %h", bus.stall_cnt, exp_stall); end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_FREEZE || bus.ctrl_state !== 2'd0) begin
      n_fail++; $display("FAIL refreeze: got %b state %0d expected %b state 0", outs(), bus.ctrl_state, O_FREEZE);
    end
    tick();
    bus.mem_ew = 1'b0;
    tick();
    tick();
    @(negedge clk);
    exp_stall = exp_stall + 16'd2;
    n_checks++;
    if (outs() !== O_NORMAL || bus.ctrl_state !== 2'd0 || bus.stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL refreeze_done: got %b state %0d stall %h expected %b state 0 stall %h",
               outs(), bus.ctrl_state, bus.stall_cnt, O_NORMAL, exp_stall);
    end
  endtask

  task automatic test_branch_during_freeze();
    tick();
    bus.mem_er = 1'b1; bus.ex_pcsrc = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_FREEZE) begin n_fail++; $display("FAIL bfrz_first: got %b expected %b", outs(), O_FREEZE); end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_FREEZE) begin n_fail++; $display("FAIL bfrz_second: got %b expected %b", outs(), O_FREEZE); end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_BRANCH) begin n_fail++; $display("FAIL bfrz_release: got %b expected %b", outs(), O_BRANCH); end
    exp_stall = exp_stall + 16'd2;
    exp_flush = exp_flush + 16'd1;
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (bus.flush_cnt !== exp_flush || bus.stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL bfrz_cnts: got flush=%h stall=%h expected flush=%h stall=%h",
               bus.flush_cnt, bus.stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_saturation();
    tick();
    bus.ex_er = 1'b1; bus.ex_AW = 5'd12; bus.id_rt = 5'd12; bus.id_uses_rt = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stall_saturate: got %h expected ffff", bus.stall_cnt); end
    n_checks++;
    if (outs() !== O_LU || bus.flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL sat_outs: got %b flush %h expected %b flush %h", outs(), bus.flush_cnt, O_LU, exp_flush);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_wait();
    tick();
    bus.mem_ew = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.ctrl_state !== 2'd1) begin n_fail++; $display("FAIL rmw_in_wait: got state %0d expected 1", bus.ctrl_state); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs() !== O_RESET) begin n_fail++; $display("FAIL rmw_reset_outs: got %b expected %b", outs(), O_RESET); end
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_checks++;
    if (outs() !== O_NORMAL || bus.ctrl_state !== 2'd0 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rmw_after: got %b state %0d stall %h flush %h expected %b state 0 stall 0000 flush 0000",
               outs(), bus.ctrl_state, bus.stall_cnt, bus.flush_cnt, O_NORMAL);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_freeze();
    test_branch_during_freeze();
    test_saturation();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
